// File: rtl/cache_pkg.sv
// Shared encodings, FSM states and default geometry for the direct-mapped,
// write-back data cache.
package cache_pkg;

    localparam int DEF_LINES          = 8;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_W         = 32;

    localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE * 4);
    localparam int INDEX_W  = $clog2(DEF_LINES);
    localparam int TAG_W    = DEF_ADDR_W - OFFSET_W - INDEX_W;

    // funct3 of loads; the low two bits double as the access size
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_op_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WRITEBACK = 2'b01,
        ALLOCATE  = 2'b10,
        UPDATE    = 2'b11
    } cache_state_e;

    // Places store data on every lane it could land on; byte enables pick the lane.
    function automatic logic [31:0] store_replicate(input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cache_ld_align.sv
// Selects the addressed word of a line and extracts/extends the byte, half or
// word; the byte enables it produces also steer store merging.
import cache_pkg::*;

module cache_ld_align #(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int OFF_W = $clog2(WORDS_PER_LINE * 4)
) (
    input  logic [32*WORDS_PER_LINE-1:0] line,
    input  logic [OFF_W-1:0]             offset,
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    output logic [31:0]                  word,
    output logic [31:0]                  rdata,
    output logic [3:0]                   byte_en
);

    logic [31:0] words [WORDS_PER_LINE];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
        assign words[gi] = line[gi*32 +: 32];
    end

    assign word     = words[offset[OFF_W-1:2]];
    assign sel_byte = word[offset[1:0]*8 +: 8];
    // Half accesses ignore offset[0]; word accesses ignore both low bits.
    assign sel_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata   = word;
        byte_en = 4'b1111;
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << offset[1:0];
                rdata   = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                rdata   = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            end
            default: begin
                byte_en = 4'b1111;
                rdata   = word;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the
// CPU MEM stage and a block-wide main memory.
import cache_pkg::*;

module data_cache #(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W,
    localparam int OFF_W  = $clog2(WORDS_PER_LINE * 4),
    localparam int IDX_W  = $clog2(LINES),
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W,
    localparam int LINE_W = 32 * WORDS_PER_LINE
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [3:0]              memReadEn,
    input  logic [2:0]              memWriteEn,
    input  logic [ADDR_W-1:0]       DATA_CACHE_ADDR,
    input  logic [31:0]             DATA_CACHE_DATA,
    output logic [31:0]             DATA_CACHE_READ_DATA,
    output logic                    DATA_CACHE_BUSY_WAIT,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-OFF_W-1:0] mem_address,
    output logic [LINE_W-1:0]       mem_writedata,
    input  logic [LINE_W-1:0]       mem_readdata,
    input  logic                    mem_busywait
);

    logic [LINE_W-1:0] data_array [LINES];
    logic [TAG_W-1:0]  tag_array  [LINES];
    logic [LINES-1:0]  valid_reg;
    logic [LINES-1:0]  dirty_reg;

    cache_state_e      state_reg, state_next;
    logic [IDX_W-1:0]  miss_idx_reg;
    logic [TAG_W-1:0]  miss_tag_reg;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              rd_req, wr_req, req, hit;
    logic              load_hit, store_hit;
    logic              mem_read_next, mem_write_next;

    logic [LINE_W-1:0] cur_line, merged_line;
    logic [31:0]       sel_word, merged_word, ld_data, st_rep;
    logic [3:0]        byte_en;

    assign req_off = DATA_CACHE_ADDR[OFF_W-1:0];
    assign req_idx = DATA_CACHE_ADDR[OFF_W +: IDX_W];
    assign req_tag = DATA_CACHE_ADDR[ADDR_W-1 -: TAG_W];

    // A simultaneous load and store request is handled as a store.
    assign wr_req = memWriteEn[2];
    assign rd_req = memReadEn[3];
    assign req    = rd_req | wr_req;
    assign hit    = valid_reg[req_idx] && (tag_array[req_idx] == req_tag);

    assign load_hit  = (state_reg == IDLE) && rd_req && !wr_req && hit;
    assign store_hit = (state_reg == IDLE) && wr_req && hit;

    assign cur_line = data_array[req_idx];

    cache_ld_align #(
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_align (
        .line       (cur_line),
        .offset     (req_off),
        .size       (wr_req ? memWriteEn[1:0] : memReadEn[1:0]),
        .is_unsigned(memReadEn[2] & ~wr_req),
        .word       (sel_word),
        .rdata      (ld_data),
        .byte_en    (byte_en)
    );

    assign st_rep = store_replicate(DATA_CACHE_DATA, memWriteEn[1:0]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
        assign merged_word[gi*8 +: 8] = byte_en[gi] ? st_rep[gi*8 +: 8] : sel_word[gi*8 +: 8];
    end

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word_merge
        assign merged_line[gi*32 +: 32] =
            (req_off[OFF_W-1:2] == gi) ? merged_word : cur_line[gi*32 +: 32];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (store_hit) begin
                dirty_reg[req_idx] <= 1'b1;
            end
            if (state_reg == UPDATE) begin
                valid_reg[miss_idx_reg] <= 1'b1;
                dirty_reg[miss_idx_reg] <= 1'b0;
            end
        end
    end

    // Miss address is latched so a request dropped mid-miss cannot steer the fill.
    always_ff @(posedge CLK) begin
        if (state_reg == IDLE && req && !hit) begin
            miss_idx_reg <= req_idx;
            miss_tag_reg <= req_tag;
        end
    end

    // Data and tag storage are left untouched by reset; valid bits gate them.
    always_ff @(posedge CLK) begin
        if (!RESET && store_hit) begin
            data_array[req_idx] <= merged_line;
        end
        if (!RESET && state_reg == UPDATE) begin
            data_array[miss_idx_reg] <= mem_readdata;
            tag_array[miss_idx_reg]  <= miss_tag_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && !hit) begin
                    state_next = dirty_reg[req_idx] ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write_next = 1'b1;
                if (!mem_busywait) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read_next = 1'b1;
                if (!mem_busywait) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_read      = mem_read_next & ~RESET;
    assign mem_write     = mem_write_next & ~RESET;
    assign mem_address   = (state_reg == WRITEBACK) ? {tag_array[miss_idx_reg], miss_idx_reg}
                                                    : {miss_tag_reg, miss_idx_reg};
    assign mem_writedata = data_array[miss_idx_reg];

    // Depends only on the current hit and state, so a hit on a dirty index never stalls.
    assign DATA_CACHE_BUSY_WAIT = !RESET && req && ((state_reg != IDLE) || !hit);
    assign DATA_CACHE_READ_DATA = (!RESET && load_hit) ? ld_data : 32'b0;

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Responder end of the CPU data-memory interface. Accepts MEM-stage load/store requests from the pipeline and returns load data.
- Drives `DATA_CACHE_BUSY_WAIT` to freeze the whole pipeline while a miss is serviced.
- Organisation: direct-mapped, write-back, write-allocate. Sits between the cpu and a block-wide main-memory model.

Parameters:
- LINES, 8, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per block (power of 2).
- ADDR_W, 32, byte-address width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- memReadEn  in  4  bit3 = load request; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- memWriteEn  in  3  bit2 = store request; [1:0] = 00 SB, 01 SH, 10 SW.
- DATA_CACHE_ADDR  in  32  byte address.
- DATA_CACHE_DATA  in  32  store data; low byte/half used for SB/SH.
- DATA_CACHE_READ_DATA  out  32  load result, sign- or zero-extended.
- DATA_CACHE_BUSY_WAIT  out  1  high = request not complete; hold all inputs stable.
- mem_read  out  1  block read request to main memory.
- mem_write  out  1  block write request to main memory.
- mem_address  out  ADDR_W-log2(WORDS_PER_LINE*4)  block address.
- mem_writedata  out  32*WORDS_PER_LINE  evicted block.
- mem_readdata  in  32*WORDS_PER_LINE  fetched block.
- mem_busywait  in  1  main memory busy.

Behaviour:
- Address split: offset = addr[3:0] (byte in block), index = addr[6:4], tag = remaining upper bits (defaults). Word select = offset[3:2].
- Sub-word alignment:
  - Half accesses use offset[1]; offset[0] is ignored.
  - Word accesses ignore offset[1:0].
  - No misalignment trap.
- Request present = memReadEn[3] | memWriteEn[2]. Both set simultaneously is illegal; the cache treats it as a store.
- Hit = valid[index] & (tag[index] == tag).
- BUSY_WAIT (combinational): high when a request is present and either (not hit, in IDLE) or state != IDLE. Low in all other cases, including no request.
- Read hit: zero stall. READ_DATA is valid combinationally in the same cycle.
- Read extension:
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - No request: READ_DATA = 0.
- Write hit: selected bytes are updated at the CLK edge; dirty[index] is set; no stall.
- FSM states: IDLE, WRITEBACK, ALLOCATE, UPDATE.
  - IDLE -> WRITEBACK: request, miss, dirty[index]=1.
  - IDLE -> ALLOCATE: request, miss, dirty[index]=0.
  - WRITEBACK: mem_write=1, mem_address={old tag, index}, mem_writedata = line. On the first edge with mem_busywait=0 -> ALLOCATE.
  - ALLOCATE: mem_read=1, mem_address={tag, index}. On the first edge with mem_busywait=0 -> UPDATE.
  - UPDATE: line <= mem_readdata, tag updated, valid=1, dirty=0 -> IDLE. The original request then hits next cycle: load data returned, or store merged and dirty set.
- mem_read and mem_write are never both high. Both are 0 in IDLE and UPDATE.
- Minimum miss penalty:
  - Clean miss: 2 + memory latency cycles.
  - Dirty miss: additionally one full writeback.
- Request dropped mid-miss (inputs deasserted): the FSM still completes the fill, with no corruption.
- Reset (synchronous, any state, including mid-writeback):
  - All valid and dirty bits cleared; FSM -> IDLE.
  - mem_read=0, mem_write=0, BUSY_WAIT=0, READ_DATA=0.
  - Data and tag arrays are not cleared.
- BUSY_WAIT must not glitch high on a hit when the index has a pending dirty line.

Decomposition:
- Package `cache_pkg`:
  - Load/store encodings (LB..LHU, SB/SH/SW).
  - FSM state enum.
  - Offset/index/tag width constants derived from the parameters.
- One sub-module `cache_ld_align`: combinational word select plus byte/half extract and sign/zero extend. Reused by the store-merge byte-enable logic.

Test Plan:
- After reset, LW 0x00000040 with memory word = 0xDEADBEEF, 5-cycle memory latency -> BUSY_WAIT high for 7 cycles, then READ_DATA = 0xDEADBEEF. An immediate repeat LW has zero stall.
- On that line, SB 0x41 data 0x000000AA, then LB 0x41 -> 0xFFFFFFAA; LBU 0x41 -> 0x000000AA; LW 0x40 -> 0xDEADAAEF. LH 0x42 -> 0xFFFFDEAD.
- Dirty line at index 4 (tag A), then LW to the same index with tag B -> mem_write asserted with the old block and old block address, then mem_read. A later reload of tag A shows the stored 0xAA.
- Two loads to different indices -> no writeback. mem_write never asserted; each miss raises mem_read only.
- RESET asserted during WRITEBACK -> next cycle mem_write=0, BUSY_WAIT=0, state IDLE. A following load to any address misses.
- SH 0x46 data 0x1234 on a clean hit line -> no stall, dirty set. LHU 0x46 -> 0x00001234.
